cfi_log_sched: RTL and testbench
================================

# cfi_log_sched

Scheduler and buffer between the commit-stage CFI log producers and the single CFI backend. Collects up to NR_COMMIT_PORTS `cfi_log_t` entries per cycle, drops non-CFI entries, queues them in commit order and hands them to the backend through a pop handshake. It stalls commit when buffer space runs low. On a backend fault it flushes, latches and reports the fault until acknowledged.

## Interface
Parameters:
- NR_COMMIT_PORTS, 2: number of commit-side log ports; range 1..4.
- DEPTH, 8: queue entries; power of two, >= 2*NR_COMMIT_PORTS.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- log_i  in  NR_COMMIT_PORTS x cfi_log_t  per-port log entry; port 0 is oldest.
- log_valid_i  in  NR_COMMIT_PORTS  per-port entry valid.
- stall_o  out  1  commit must not present new entries.
- log_o  out  cfi_log_t  queue head to the backend.
- queue_empty_o  out  1  no entry available at log_o.
- queue_pop_i  in  1  backend consumes the head.
- bknd_fault_i  in  exception_t  fault from the backend; `.valid` qualifies.
- fault_o  out  exception_t  latched fault toward commit/CSR.
- fault_ack_i  in  1  commit has taken the fault.

## Operation
- An entry is eligible when log_valid_i[k]=1, log_i[k].flags != 4'b0000, stall_o=0 and state=RUN.
- Eligible entries are written in ascending port order into consecutive slots. Ineligible ports leave no hole.
- Count: width $clog2(DEPTH+1); next = count + pushes − pop.
- Read and write pointers: $clog2(DEPTH) bits, wrap modulo DEPTH.
- stall_o = (count > DEPTH − NR_COMMIT_PORTS) or state != RUN, computed from registered count only.
- A pop in the same cycle does not lower stall_o.
- The producer must honour stall_o. Entries presented while stall_o=1 are discarded, never overwritten into the queue.
- queue_pop_i with an empty queue is ignored. Pointers and count are unchanged.
- States:
  - RUN: normal operation. bknd_fault_i.valid=1 goes to FAULT, latches bknd_fault_i into fault_o, and clears count and pointers at the same edge. Pushes and the pop in that cycle are discarded.
  - FAULT: fault_o held stable with `.valid`=1, queue_empty_o=1, stall_o=1, queue_pop_i ignored, further bknd_fault_i ignored. fault_ack_i=1 goes to RUN, and fault_o clears at that edge.
- Reset values: state RUN, count 0, pointers 0, stall_o 0, queue_empty_o 1, fault_o all zeros, log_o all zeros (storage reset).
- Reset mid-operation discards all queued entries and any latched fault immediately, asynchronously.

## Timing
- Push-to-visible latency 1 cycle. An entry written at edge N appears at log_o with queue_empty_o=0 after edge N.
- log_o and queue_empty_o are registered-state functions: a mux on the read pointer, with no combinational path from log_i.
- Pop: the head advances at the edge where queue_pop_i=1 and queue_empty_o=0. The new head is valid the following cycle.
- Full pipelined throughput: one pop per cycle and up to NR_COMMIT_PORTS pushes per cycle.
- Fault path: bknd_fault_i at cycle N gives fault_o.valid=1 from N+1. fault_ack_i at cycle M gives RUN and fault_o=0 from M+1, with stall_o low from M+1 since count=0.
- Simultaneous push and pop at count=DEPTH−1 is legal only if stall_o=0, which guarantees no overflow.

## Configuration
- CFI_SCHED_STATS_EN defined: adds output `hwm_o` with width $clog2(DEPTH+1).
  - Registered high-water mark of count.
  - Reset to 0; never cleared by a fault.
  - Updates one cycle after count exceeds it.
- CFI_SCHED_STATS_EN undefined: port and logic are absent; behaviour otherwise identical.

## Test plan
- Reset then idle → queue_empty_o=1, stall_o=0, fault_o.valid=0, log_o=0.
- Single branch: log_valid_i=2'b01, flags 4'b1000 at cycle 0 → queue_empty_o=0 at cycle 1 with that entry at log_o. Pop at cycle 1 → empty at cycle 2.
- Dual push with port 0 flags 0000 and port 1 call 0010 → exactly one entry queued; log_o=port 1 entry.
- Fill with DEPTH=8, NR_COMMIT_PORTS=2: push 2 per cycle, no pop → stall_o=1 once count=7..8. Extra valid entries are discarded; count never exceeds 8. Then 8 pops return entries in commit order, pointers wrapped.
- Fault with 5 entries queued: bknd_fault_i.valid=1 → next cycle fault_o equals the injected value, queue_empty_o=1, stall_o=1, pops ignored. fault_ack_i at cycle +3 → RUN, count 0, stall_o=0.
- With CFI_SCHED_STATS_EN: fill to 6, drain, fault, ack → hwm_o=6 throughout after the peak.

Source files
------------

// File: rtl/cfi_log_sched.sv
// cfi_log_sched: buffers CFI log entries from the commit ports and hands them
// to a single CFI backend through a pop handshake. Non-CFI entries are dropped,
// commit is stalled when space runs low, and a backend fault flushes the queue
// and is held on fault_o until commit acknowledges it.
// Optional feature: define CFI_SCHED_STATS_EN to add the hwm_o high-water mark.

package cfi_log_sched_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [3:0]  flags;
  } cfi_log_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

endpackage

module cfi_log_sched
  import cfi_log_sched_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0]   log_i,
  input  logic     [NR_COMMIT_PORTS-1:0]   log_valid_i,
  output logic                             stall_o,
  output cfi_log_t                         log_o,
  output logic                             queue_empty_o,
  input  logic                             queue_pop_i,
  input  exception_t                       bknd_fault_i,
  output exception_t                       fault_o,
  input  logic                             fault_ack_i
`ifdef CFI_SCHED_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]       hwm_o
`else
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  exception_t    fault_q, fault_d;
  cfi_log_t      mem_q [DEPTH];

  logic [NR_COMMIT_PORTS-1:0] elig;
  logic [PW-1:0]              slot [NR_COMMIT_PORTS];
  logic [CW-1:0]              push_cnt;
  logic                       pop_ok;
  logic                       fault_take;

  // Outputs depend on registered state only; stall ignores a same-cycle pop.
  assign stall_o       = (count_q > CW'(DEPTH - NR_COMMIT_PORTS)) || (state_q != RUN);
  assign queue_empty_o = (count_q == '0) || (state_q != RUN);
  assign log_o         = mem_q[rptr_q];
  assign fault_o       = fault_q;

  // Compact eligible ports into consecutive slots, oldest port first.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      elig[k] = log_valid_i[k] && (log_i[k].flags != 4'b0000) && !stall_o;
      slot[k] = wptr_q + PW'(push_cnt);
      if (elig[k]) begin
        push_cnt = push_cnt + CW'(1);
      end
    end
  end

  assign pop_ok     = queue_pop_i && (state_q == RUN) && (count_q != '0);
  assign fault_take = (state_q == RUN) && bknd_fault_i.valid;

  // Next-state for the FSM, occupancy, pointers and the latched fault.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    count_d = count_q + push_cnt - CW'(pop_ok);
    wptr_d  = wptr_q + PW'(push_cnt);
    rptr_d  = rptr_q + PW'(pop_ok);
    case (state_q)
      RUN: begin
        if (bknd_fault_i.valid) begin
          // Flush: this cycle's pushes and pop are dropped together.
          state_d = FAULT;
          fault_d = bknd_fault_i;
          count_d = '0;
          wptr_d  = '0;
          rptr_d  = '0;
        end
      end
      default: begin
        if (fault_ack_i) begin
          state_d = RUN;
          fault_d = '0;
        end
      end
    endcase
  end

  // Control and fault registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fault_q <= fault_d;
    end
  end

  // Queue storage; cleared on reset so log_o reads zero when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!fault_take) begin
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (elig[k]) begin
          mem_q[slot[k]] <= log_i[k];
        end
      end
    end
  end

`ifdef CFI_SCHED_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;

  assign hwm_d = (count_q > hwm_q) ? count_q : hwm_q;
  assign hwm_o = hwm_q;

  // High-water mark of occupancy; survives faults, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end
`else
  // Statistics disabled: no high-water mark logic.
`endif

endmodule

// File: tb/tb_cfi_log_sched.sv
// Directed testbench for cfi_log_sched (NR_COMMIT_PORTS=2, DEPTH=8).
module tb_cfi_log_sched;
  import cfi_log_sched_pkg::*;

  logic                 clk;
  logic                 rst_n;
  cfi_log_t [1:0]       log_i;
  logic     [1:0]       log_valid_i;
  logic                 stall_o;
  cfi_log_t             log_o;
  logic                 queue_empty_o;
  logic                 queue_pop_i;
  exception_t           bknd_fault_i;
  exception_t           fault_o;
  logic                 fault_ack_i;
`ifdef CFI_SCHED_STATS_EN
  logic [3:0]           hwm_o;
`endif

  int n_cmp;
  int n_err;

  cfi_log_sched #(.NR_COMMIT_PORTS(2), .DEPTH(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .log_i         (log_i),
    .log_valid_i   (log_valid_i),
    .stall_o       (stall_o),
    .log_o         (log_o),
    .queue_empty_o (queue_empty_o),
    .queue_pop_i   (queue_pop_i),
    .bknd_fault_i  (bknd_fault_i),
    .fault_o       (fault_o),
    .fault_ack_i   (fault_ack_i)
`ifdef CFI_SCHED_STATS_EN
    ,
    .hwm_o         (hwm_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  f0;
    logic [31:0] pc0;
    logic [3:0]  f1;
    logic [31:0] pc1;
    logic        pop;
    logic        e_empty;
    logic        e_stall;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] f0, input logic [31:0] pc0,
                       input logic [3:0] f1, input logic [31:0] pc1, input logic pop);
    log_valid_i     = v;
    log_i[0].pc     = pc0;
    log_i[0].target = pc0 + 32'h40;
    log_i[0].flags  = f0;
    log_i[1].pc     = pc1;
    log_i[1].target = pc1 + 32'h40;
    log_i[1].flags  = f1;
    queue_pop_i     = pop;
  endtask

  task automatic idle();
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    bknd_fault_i = '0;
    fault_ack_i  = 1'b0;
  endtask

  exception_t inj;
  exception_t inj2;
  int         cnt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();

    tbl[0]  = '{2'b01, 4'b1000, 32'h100, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b0, 32'h100};
    tbl[1]  = '{2'b00, 4'b0000, 32'h0,   4'b0000, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{2'b11, 4'b0000, 32'h200, 4'b0010, 32'h204, 1'b0, 1'b0, 1'b0, 32'h204};
    tbl[3]  = '{2'b00, 4'b0000, 32'h0,   4'b0000, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{2'b10, 4'b1000, 32'h2FF, 4'b0001, 32'h300, 1'b0, 1'b0, 1'b0, 32'h300};
    tbl[5]  = '{2'b11, 4'b0100, 32'h400, 4'b0100, 32'h404, 1'b1, 1'b0, 1'b0, 32'h400};
    tbl[6]  = '{2'b00, 4'b0000, 32'h0,   4'b0000, 32'h0,   1'b1, 1'b0, 1'b0, 32'h404};
    tbl[7]  = '{2'b00, 4'b0000, 32'h0,   4'b0000, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{2'b00, 4'b0000, 32'h0,   4'b0000, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{2'b01, 4'b1000, 32'h500, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b0, 32'h500};
    tbl[10] = '{2'b00, 4'b0000, 32'h0,   4'b0000, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0};

    // Reset and idle
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_empty", queue_empty_o, 1'b1);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_fault_valid", fault_o.valid, 1'b0);
    chk("rst_log", log_o, '0);
`ifdef CFI_SCHED_STATS_EN
    chk("rst_hwm", hwm_o, 4'd0);
`endif

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].f0, tbl[i].pc0, tbl[i].f1, tbl[i].pc1, tbl[i].pop);
      tick();
      idle();
      chk($sformatf("vec%0d_empty", i), queue_empty_o, tbl[i].e_empty);
      chk($sformatf("vec%0d_stall", i), stall_o, tbl[i].e_stall);
      if (!tbl[i].e_empty) chk($sformatf("vec%0d_pc", i), log_o.pc, tbl[i].e_pc);
    end

    // Fill: two pushes per cycle, no pops; excess entries must be discarded
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      drive(2'b11, 4'b0001, 32'h1000 + 32'(8 * c), 4'b0001, 32'h1004 + 32'(8 * c), 1'b0);
      tick();
      idle();
      if (cnt <= 6) cnt = cnt + 2;
      chk($sformatf("fill%0d_stall", c), stall_o, (cnt > 6));
    end
    // Drain in commit order, across the pointer wrap
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d_empty", j), queue_empty_o, 1'b0);
      chk($sformatf("drain%0d_pc", j), log_o.pc, 32'h1000 + 32'(4 * j));
      chk($sformatf("drain%0d_tgt", j), log_o.target, 32'h1040 + 32'(4 * j));
      queue_pop_i = 1'b1;
      tick();
      idle();
      cnt--;
      chk($sformatf("drain%0d_stall", j), stall_o, (cnt > 6));
    end
    chk("drain_done_empty", queue_empty_o, 1'b1);

    // Fault with 5 entries queued
    drive(2'b11, 4'b1000, 32'h600, 4'b1000, 32'h604, 1'b0); tick();
    drive(2'b11, 4'b1000, 32'h608, 4'b1000, 32'h60C, 1'b0); tick();
    drive(2'b01, 4'b1000, 32'h610, 4'b0000, 32'h0,   1'b0); tick();
    inj  = '{cause: 32'hDEAD, tval: 32'h1234, valid: 1'b1};
    inj2 = '{cause: 32'hBEEF, tval: 32'h5678, valid: 1'b1};
    drive(2'b11, 4'b1000, 32'h614, 4'b1000, 32'h618, 1'b1);
    bknd_fault_i = inj;
    tick();
    idle();
    chk("flt_latch", fault_o, inj);
    chk("flt_empty", queue_empty_o, 1'b1);
    chk("flt_stall", stall_o, 1'b1);
    queue_pop_i  = 1'b1;
    bknd_fault_i = inj2;
    tick();
    idle();
    chk("flt_hold", fault_o, inj);
    chk("flt_hold_empty", queue_empty_o, 1'b1);
    tick();
    chk("flt_hold2_stall", stall_o, 1'b1);
    fault_ack_i = 1'b1;
    tick();
    idle();
    chk("ack_fault_clr", fault_o, '0);
    chk("ack_stall", stall_o, 1'b0);
    chk("ack_empty", queue_empty_o, 1'b1);
    drive(2'b01, 4'b0100, 32'h700, 4'b0000, 32'h0, 1'b0);
    tick();
    idle();
    chk("post_ack_pc", log_o.pc, 32'h700);
    queue_pop_i = 1'b1;
    tick();
    idle();
    chk("post_ack_count0", queue_empty_o, 1'b1);
`ifdef CFI_SCHED_STATS_EN
    chk("hwm_peak", hwm_o, 4'd8);
`endif

    // Asynchronous reset mid-operation
    drive(2'b01, 4'b1000, 32'h800, 4'b0000, 32'h0, 1'b0);
    tick();
    idle();
    chk("pre_arst_empty", queue_empty_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", queue_empty_o, 1'b1);
    chk("arst_log", log_o, '0);
    #1 rst_n = 1'b1;
    tick();
    chk("arst_after_stall", stall_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
